// File: rtl/deser_pkg.sv
// Shared definitions for the parameterised serial-to-parallel deserializer.
package deser_pkg;

   // FSM state codes; 2'b11 is unused and recovers to ST_IDLE.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_SHIFT  = 2'b01,
      ST_PARITY = 2'b10
   } state_t;

endpackage

// File: rtl/deser_shifter.sv
// Shift register, saturating bit counter and running parity for one frame.
// word_nxt/parity_nxt expose the values after the current cycle's shift, so
// the last data bit can complete a frame in the same cycle it arrives.
module deser_shifter
   import deser_pkg::*;
#(
   parameter int WIDTH = 14,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             shift_en,
   input  logic             clear,
   input  logic             msb_first,
   input  logic             data_in,
   output logic [WIDTH-1:0] word,
   output logic [WIDTH-1:0] word_nxt,
   output logic [CW-1:0]    count,
   output logic             parity,
   output logic             parity_nxt
);

   // Next word and parity if data_in is shifted in this cycle.
   always_comb begin
      word_nxt   = msb_first ? {word[WIDTH-2:0], data_in} : {data_in, word[WIDTH-1:1]};
      parity_nxt = parity ^ data_in;
   end

   // Shift, count and accumulate parity; the counter saturates at WIDTH.
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         word   <= '0;
         count  <= '0;
         parity <= 1'b0;
      end else if (shift_en) begin
         word   <= word_nxt;
         parity <= parity_nxt;
         if (count != CW'(WIDTH))
            count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/param_deserializer.sv
// Serial-to-parallel deserializer with optional even parity, a holding
// register and a ready/ack handshake.
// Handshake: ready=1 means data_out/parity_err hold an unacknowledged word;
// ack=1 while ready=1 consumes it (ready drops next clock). A frame that
// completes while an unacknowledged word is held is dropped and sets the
// sticky overrun flag; ack clears overrun unless a drop happens that cycle.
module param_deserializer
   import deser_pkg::*;
#(
   parameter int WIDTH     = 14,
   parameter int MSB_FIRST = 1,
   parameter int PARITY_EN = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ss,
   input  logic             data_in,
   input  logic             ack,
   output logic [WIDTH-1:0] data_out,
   output logic             ready,
   output logic             parity_err,
   output logic             overrun,
   output logic [1:0]       state
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t           state_r;
   logic [WIDTH-1:0] word;
   logic [WIDTH-1:0] word_nxt;
   logic [CW-1:0]    count;
   logic             parity;
   logic             parity_nxt;
   logic             shift_en;
   logic             clear;
   logic             last_bit;
   logic             complete;
   logic             accept;
   logic             discard;
   logic [WIDTH-1:0] frame_word;
   logic             frame_perr;

   deser_shifter #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_shifter (
      .clock      (clock),
      .reset      (reset),
      .shift_en   (shift_en),
      .clear      (clear),
      .msb_first  (MSB_FIRST != 0),
      .data_in    (data_in),
      .word       (word),
      .word_nxt   (word_nxt),
      .count      (count),
      .parity     (parity),
      .parity_nxt (parity_nxt)
   );

   // Frame completion and handshake decisions for this cycle.
   always_comb begin
      shift_en   = (state_r == ST_SHIFT);
      clear      = (state_r == ST_IDLE) && ss;
      last_bit   = (state_r == ST_SHIFT) && (count == CW'(WIDTH - 1));
      complete   = (last_bit && (PARITY_EN == 0)) || (state_r == ST_PARITY);
      frame_word = (state_r == ST_PARITY) ? word : word_nxt;
      frame_perr = (PARITY_EN != 0) ? (parity ^ data_in) : 1'b0;
      accept     = complete && (!ready || ack);
      discard    = complete && ready && !ack;
   end

   // FSM, holding register and handshake flags.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         data_out   <= '0;
         ready      <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE:   if (ss) state_r <= ST_SHIFT;
            ST_SHIFT:  if (last_bit) state_r <= (PARITY_EN != 0) ? ST_PARITY : ST_IDLE;
            ST_PARITY: state_r <= ST_IDLE;
            default:   state_r <= ST_IDLE;
         endcase

         if (accept) begin
            data_out   <= frame_word;
            parity_err <= frame_perr;
            ready      <= 1'b1;
         end else if (ack && ready && !complete) begin
            ready      <= 1'b0;
            parity_err <= 1'b0;
         end

         if (discard)
            overrun <= 1'b1;
         else if (ack)
            overrun <= 1'b0;
      end
   end

   assign state = state_r;

endmodule

// File: tb/tb_param_deserializer.sv
// Directed bench: three deserializer variants fed the same serial stream.
module tb_param_deserializer;

   localparam int W = 14;

   logic         clock;
   logic         reset;
   logic         ss;
   logic         data_in;
   logic         ack;

   logic [W-1:0] d0_data, d1_data, d2_data;
   logic         d0_ready, d1_ready, d2_ready;
   logic         d0_perr, d1_perr, d2_perr;
   logic         d0_ovr, d1_ovr, d2_ovr;
   logic [1:0]   d0_state, d1_state, d2_state;

   int tests;
   int fails;

   // MSB first, no parity
   param_deserializer #(.WIDTH(W), .MSB_FIRST(1), .PARITY_EN(0)) u_d0 (
      .clock(clock), .reset(reset), .ss(ss), .data_in(data_in), .ack(ack),
      .data_out(d0_data), .ready(d0_ready), .parity_err(d0_perr),
      .overrun(d0_ovr), .state(d0_state));

   // LSB first, no parity
   param_deserializer #(.WIDTH(W), .MSB_FIRST(0), .PARITY_EN(0)) u_d1 (
      .clock(clock), .reset(reset), .ss(ss), .data_in(data_in), .ack(ack),
      .data_out(d1_data), .ready(d1_ready), .parity_err(d1_perr),
      .overrun(d1_ovr), .state(d1_state));

   // MSB first, even parity
   param_deserializer #(.WIDTH(W), .MSB_FIRST(1), .PARITY_EN(1)) u_d2 (
      .clock(clock), .reset(reset), .ss(ss), .data_in(data_in), .ack(ack),
      .data_out(d2_data), .ready(d2_ready), .parity_err(d2_perr),
      .overrun(d2_ovr), .state(d2_state));

   // Clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [W-1:0] word;
      logic [W-1:0] rev;
      logic         par_bit;
      logic         perr;
      logic         ss_hold;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      ss      = 1'b0;
      data_in = 1'b0;
      ack     = 1'b0;
      step();
      step();
      reset = 1'b0;
   endtask

   // ss cycle then W data bits MSB first; returns in cycle W+1.
   task automatic send(input logic [W-1:0] word, input logic ss_hold,
                       input logic ack_last, input logic chk_pre);
      logic [W-1:0] w;
      w       = word;
      ss      = 1'b1;
      data_in = 1'b1;
      step();
      for (int i = W - 1; i >= 0; i--) begin
         data_in = w[i];
         ss      = ss_hold;
         ack     = (i == 0) ? ack_last : 1'b0;
         if (i == 0 && chk_pre) check("ready_before_last", {31'd0, d0_ready}, 32'd0);
         step();
      end
      ss  = 1'b0;
      ack = 1'b0;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b1; ss = 1'b0; data_in = 1'b0; ack = 1'b0;

      vecs[0] = '{word: 14'h2A5C, rev: 14'h0E95, par_bit: 1'b1, perr: 1'b0, ss_hold: 1'b0};
      vecs[1] = '{word: 14'h2A5C, rev: 14'h0E95, par_bit: 1'b0, perr: 1'b1, ss_hold: 1'b0};
      vecs[2] = '{word: 14'h0001, rev: 14'h2000, par_bit: 1'b1, perr: 1'b0, ss_hold: 1'b0};
      vecs[3] = '{word: 14'h3FFF, rev: 14'h3FFF, par_bit: 1'b0, perr: 1'b0, ss_hold: 1'b1};
      vecs[4] = '{word: 14'h1234, rev: 14'h0B12, par_bit: 1'b0, perr: 1'b1, ss_hold: 1'b1};
      vecs[5] = '{word: 14'h0ABC, rev: 14'h0F54, par_bit: 1'b1, perr: 1'b0, ss_hold: 1'b0};

      // Reset state
      do_reset();
      check("rst_data", {18'd0, d0_data}, 32'd0);
      check("rst_ready", {31'd0, d0_ready}, 32'd0);
      check("rst_perr", {31'd0, d2_perr}, 32'd0);
      check("rst_ovr", {31'd0, d0_ovr}, 32'd0);
      check("rst_state", {30'd0, d2_state}, 32'd0);

      // Table-driven frames
      for (int v = 0; v < 6; v++) begin
         do_reset();
         send(vecs[v].word, vecs[v].ss_hold, 1'b0, 1'b1);
         check("d0_ready", {31'd0, d0_ready}, 32'd1);
         check("d0_data", {18'd0, d0_data}, {18'd0, vecs[v].word});
         check("d0_perr", {31'd0, d0_perr}, 32'd0);
         check("d1_data", {18'd0, d1_data}, {18'd0, vecs[v].rev});
         check("d1_ready", {31'd0, d1_ready}, 32'd1);
         check("d2_ready_early", {31'd0, d2_ready}, 32'd0);
         check("d2_state_par", {30'd0, d2_state}, 32'd2);
         data_in = vecs[v].par_bit;
         step();
         check("d2_ready", {31'd0, d2_ready}, 32'd1);
         check("d2_data", {18'd0, d2_data}, {18'd0, vecs[v].word});
         check("d2_perr", {31'd0, d2_perr}, {31'd0, vecs[v].perr});
         check("d2_state_idle", {30'd0, d2_state}, 32'd0);
         ack = 1'b1;
         step();
         ack = 1'b0;
         check("ack_d0_ready", {31'd0, d0_ready}, 32'd0);
         check("ack_d2_ready", {31'd0, d2_ready}, 32'd0);
         check("ack_d2_perr", {31'd0, d2_perr}, 32'd0);
         check("ack_d0_hold", {18'd0, d0_data}, {18'd0, vecs[v].word});
      end

      // Overrun: second frame dropped while first is unacknowledged
      do_reset();
      send(14'h0001, 1'b0, 1'b0, 1'b0);
      data_in = 1'b0;
      step();
      check("ovr_first_ready", {31'd0, d0_ready}, 32'd1);
      send(14'h3FFF, 1'b0, 1'b0, 1'b0);
      check("ovr_data", {18'd0, d0_data}, 32'h0001);
      check("ovr_flag", {31'd0, d0_ovr}, 32'd1);
      check("ovr_ready", {31'd0, d0_ready}, 32'd1);
      ack = 1'b1;
      step();
      ack = 1'b0;
      check("ovr_ack_ready", {31'd0, d0_ready}, 32'd0);
      check("ovr_ack_flag", {31'd0, d0_ovr}, 32'd0);
      check("ovr_ack_hold", {18'd0, d0_data}, 32'h0001);

      // ack in the completion cycle of a second frame
      do_reset();
      send(14'h0001, 1'b0, 1'b0, 1'b0);
      data_in = 1'b0;
      step();
      send(14'h1234, 1'b1, 1'b1, 1'b0);
      check("sim_data", {18'd0, d0_data}, 32'h1234);
      check("sim_ready", {31'd0, d0_ready}, 32'd1);
      check("sim_ovr", {31'd0, d0_ovr}, 32'd0);
      check("sim_d1_data", {18'd0, d1_data}, 32'h0B12);

      // Reset at bit 7 of a frame, then ss right after reset releases
      do_reset();
      send(14'h0001, 1'b0, 1'b0, 1'b0);
      data_in = 1'b0;
      step();
      ss = 1'b1;
      step();
      ss = 1'b0;
      for (int i = 0; i < 7; i++) begin
         data_in = i[0];
         step();
      end
      reset = 1'b1;
      step();
      check("mid_rst_data", {18'd0, d0_data}, 32'd0);
      check("mid_rst_ready", {31'd0, d0_ready}, 32'd0);
      check("mid_rst_ovr", {31'd0, d0_ovr}, 32'd0);
      check("mid_rst_state", {30'd0, d0_state}, 32'd0);
      check("mid_rst_d2_data", {18'd0, d2_data}, 32'd0);
      reset = 1'b0;
      send(14'h0ABC, 1'b0, 1'b0, 1'b1);
      check("post_rst_data", {18'd0, d0_data}, 32'h0ABC);
      check("post_rst_ready", {31'd0, d0_ready}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/param_deserializer.md
PARAM_DESERIALIZER -- requirements
Module: param_deserializer

Interface
REQ-001 SHALL have parameter WIDTH, default 14: data bits per frame, legal range 2..32.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 means the first received bit lands in data_out[WIDTH-1]; 0 means it lands in data_out[0].
REQ-003 SHALL have parameter PARITY_EN, default 0: 1 means one even-parity bit follows the data bits.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 Port clock, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1 bit: synchronous, active-high.
REQ-007 Port ss, input, 1 bit: start strobe, sampled only in IDLE.
REQ-008 Port data_in, input, 1 bit: serial data, one bit per clock.
REQ-009 Port ack, input, 1 bit: consumer acknowledge of the held word.
REQ-010 Port data_out, output, WIDTH bits: holding register for the last accepted frame.
REQ-011 Port ready, output, 1 bit: data_out is valid and not yet acknowledged.
REQ-012 Port parity_err, output, 1 bit: parity result for the held word; always 0 when PARITY_EN=0.
REQ-013 Port overrun, output, 1 bit: sticky; a completed frame was dropped.
REQ-014 Port state, output, 2 bits: current FSM state code.

Function
REQ-015 FSM SHALL have three states: IDLE=00, SHIFT=01, PARITY=10; code 11 is unused and SHALL recover to IDLE on the next clock.
- REQ-016 IDLE, ss=1: go to SHIFT and clear the bit counter; data_in is ignored in this cycle.
- REQ-017 IDLE, ss=0: remain in IDLE.
REQ-018 In SHIFT, SHALL capture data_in each cycle into the shift register in MSB_FIRST order and increment the counter.
REQ-019 ss SHALL be ignored outside IDLE.
REQ-020 Frame completion: after WIDTH SHIFT cycles, go to PARITY if PARITY_EN=1, else complete the frame and go to IDLE.
REQ-021 PARITY SHALL last one cycle.
- Samples data_in as the parity bit.
- parity error = XOR of the WIDTH data bits and the parity bit (nonzero is an error).
- Completes the frame and goes to IDLE.
REQ-022 Latency: with ss high in cycle 0 and data bits in cycles 1..WIDTH, ready SHALL be 1 in cycle WIDTH+1 (PARITY_EN=0) or WIDTH+2 (PARITY_EN=1).
REQ-023 On completion with ready=0, or with ready=1 and ack=1 in the same cycle:
- data_out <= assembled word;
- parity_err <= computed result;
- ready <= 1.
REQ-024 On completion with ready=1 and ack=0:
- the frame is discarded;
- data_out, parity_err and ready are unchanged;
- overrun <= 1.
REQ-025 ack=1 with ready=1 and no completion that cycle SHALL clear ready and parity_err on the next clock.
REQ-026 ack=1 SHALL clear overrun on the next clock, unless a discard under REQ-024 occurs in the same cycle, in which case overrun stays 1.
REQ-027 ack while ready=0 SHALL have no effect other than REQ-026.
REQ-028 data_out SHALL change only on accepted completions (REQ-023); it is never cleared by ack.
REQ-029 IDLE SHALL be re-entered after completion, so back-to-back frames need ss again; minimum frame period is WIDTH+1 (PARITY_EN=0) or WIDTH+2 (PARITY_EN=1) cycles.
REQ-030 Bit counter SHALL be $clog2(WIDTH+1) bits wide and SHALL NOT wrap within a frame.

Reset
REQ-031 While reset=1 at a clock edge, the block SHALL set:
- state=IDLE, counter=0, shift register=0;
- data_out=0, ready=0, parity_err=0, overrun=0.
REQ-032 Reset mid-frame SHALL abandon the partial frame with no ready pulse; ss in the first cycle after reset deasserts SHALL be honoured.
REQ-033 reset SHALL take priority over ss, ack and data_in.

Structure
REQ-034 State encodings (IDLE, SHIFT, PARITY) SHALL live in shared package deser_pkg, together with the 2-bit state type.
REQ-035 A single sub-module deser_shifter SHALL hold the shift register, bit counter and running parity, with signals:
- inputs: shift-enable, clear, MSB_FIRST;
- outputs: word, count, parity.
REQ-036 The FSM, holding register and handshake SHALL be in param_deserializer.

Verification
REQ-037 Frame, WIDTH=14, MSB_FIRST=1, PARITY_EN=0: ss, then bits of 14'h2A5C MSB first -> ready=1 at cycle 15, data_out=14'h2A5C, parity_err=0.
REQ-038 Same bit stream with MSB_FIRST=0 -> data_out = bit-reverse of 14'h2A5C = 14'h0E95.
REQ-039 Parity, PARITY_EN=1, frame 14'h2A5C (seven ones):
- parity bit 1 -> ready at cycle 16, parity_err=0;
- parity bit 0 -> parity_err=1.
REQ-040 Overrun: first frame 14'h0001 with no ack, second frame 14'h3FFF -> data_out=14'h0001, overrun=1; then ack -> ready=0 and overrun=0 next cycle.
REQ-041 Simultaneous events:
- ack asserted in the completion cycle of a second frame (14'h1234) -> data_out=14'h1234, ready stays 1, overrun=0.
- ss asserted during SHIFT -> no effect.
REQ-042 Reset asserted at bit 7 of a frame -> all outputs 0 next cycle; a fresh ss and frame 14'h0ABC -> data_out=14'h0ABC.
